icb_addr_dec_5: RTL and testbench
=================================

# icb_addr_dec_5

Address decoder and ordering guard sitting directly upstream of the 5-to-1 ICB mux. It takes the single ICB initiator stream, decodes each command address to one of five slave regions, and drives the mux `sel` input. It holds `sel` stable while responses are outstanding and stalls any command that targets a different slave until the current one has drained. Commands to unmapped addresses complete locally with an error response.

## Interface
Parameters:
- `S0_BASE`, default 32'h1000_0000: region base, slave 0.
- `S1_BASE`, default 32'h2000_0000: region base, slave 1.
- `S2_BASE`, default 32'h3000_0000: region base, slave 2.
- `S3_BASE`, default 32'h4000_0000: region base, slave 3.
- `S4_BASE`, default 32'h5000_0000: region base, slave 4.
- `REGION_MASK`, default 32'hF000_0000: compare mask applied to all regions.
- `MAX_OST`, default 4: maximum outstanding commands; range 1..15.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `m_cmd`  in  icb_cmd_m_t  initiator command (valid, addr, read, wdata, wmask, size).
- `m_cmd_rsp`  out  icb_cmd_s_t  command ready to initiator.
- `m_rsp`  out  icb_rsp_s_t  response to initiator (rsp_valid, rsp_rdata, rsp_err).
- `m_rsp_ready`  in  icb_rsp_m_t  initiator response ready.
- `x_cmd`  out  icb_cmd_m_t  command to mux master port.
- `x_cmd_rsp`  in  icb_cmd_s_t  mux command ready.
- `x_rsp`  in  icb_rsp_s_t  mux response.
- `x_rsp_ready`  out  icb_rsp_m_t  response ready to mux.
- `sel`  out  3  mux select, 0..4.

## Operation
- Decode: hit_i = ((addr & REGION_MASK) == (Si_BASE & REGION_MASK)); lowest index wins on overlap; no hit = unmapped.
- Registers: `cnt` (outstanding count, 4 bits), `sel_q` (locked slave), `state` in {IDLE, BUSY, ERR}.
- IDLE (cnt==0): `sel` = dec_sel if `m_cmd.valid` and mapped, else `sel_q`. Mapped command: `x_cmd.valid` = `m_cmd.valid`, `m_cmd_rsp.ready` = `x_cmd_rsp.ready`; on handshake sel_q<=dec_sel, cnt<=1, ->BUSY. Unmapped command: `x_cmd.valid`=0, `m_cmd_rsp.ready`=1; on handshake ->ERR.
- BUSY (cnt>0): `sel`=`sel_q`. Command forwarded only if mapped, dec_sel==sel_q and cnt<MAX_OST; otherwise `x_cmd.valid`=0 and `m_cmd_rsp.ready`=0 (stall). Unmapped commands also stall in BUSY.
- cnt: +1 on x cmd handshake, -1 on x rsp handshake (`x_rsp.rsp_valid & m_rsp_ready.rsp_ready`), unchanged on both. cnt reaching 0 -> IDLE; sel_q retained.
- Stall decisions use registered cnt: a response draining the last outstanding in the same cycle as a different-slave command still stalls that command; it proceeds next cycle from IDLE.
- Responses in IDLE/BUSY: `m_rsp` = `x_rsp`, `x_rsp_ready` = `m_rsp_ready`.
- ERR: `m_rsp.rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0; `x_rsp_ready`=0; `m_cmd_rsp.ready`=0; on `m_rsp_ready.rsp_ready` ->IDLE.
- Payload fields (addr, read, wdata, wmask, size) pass to `x_cmd` unconditionally.

## Timing
- Reset: cnt=0, sel_q=0, state=IDLE; `sel`=0, `x_cmd.valid`=0, `m_rsp.rsp_valid`=0, `m_cmd_rsp.ready`=0 while `m_cmd.valid`=0.
- Mapped command path combinational, zero added latency; responses pass through zero-cycle.
- Unmapped error response valid the cycle after command handshake; held until accepted.
- Response in same cycle as command handshake legal in every state.
- Reset mid-transaction: all state cleared immediately; in-flight downstream responses after reset are the system's responsibility.
- cnt never exceeds MAX_OST, never underflows (response while cnt==0 is a protocol error; ignored, `x_rsp_ready` still forwarded).

## Test plan
- Read 0x2000_0010, slave ready, response next cycle -> `sel`=1, cnt 0->1->0, rdata forwarded unchanged.
- Four back-to-back writes to 0x3000_0000 with responses withheld -> all accepted, cnt=4; fifth stalls (`m_cmd_rsp.ready`=0) until one response, then accepted same cycle cnt is 3.
- Read to slave 0 outstanding, then command to 0x4000_0000 -> stalled, `sel` stays 0 until response handshake; next cycle `sel`=3, forwarded.
- Command to 0x9000_0000 in IDLE -> accepted with ready=1, `x_cmd.valid`=0; next cycle rsp_valid=1, rsp_err=1, rdata=0; with `m_rsp_ready` low 3 cycles, held until accepted.
- Simultaneous cmd handshake and response with cnt=2 to same slave -> cnt stays 2, `sel` unchanged.
- Assert `rst_n` low with cnt=3 -> same cycle cnt=0, `sel`=0, state IDLE; outputs per reset values.

Source files
------------

// File: rtl/icb_addr_dec_5.sv
// rtl/icb_addr_dec_5.sv - ICB address decoder and ordering guard ahead of a 5-to-1 ICB mux
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   m_cmd        initiator command in      m_cmd_rsp    command ready to initiator
//   m_rsp        response to initiator     m_rsp_ready  initiator response ready
//   x_cmd        command to mux            x_cmd_rsp    mux command ready
//   x_rsp        response from mux         x_rsp_ready  response ready to mux
//   sel          mux select (0..4)

package icb_addr_dec_5_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        read;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [1:0]  size;
    } icb_cmd_m_t;

    typedef struct packed {
        logic ready;
    } icb_cmd_s_t;

    typedef struct packed {
        logic        rsp_valid;
        logic [31:0] rsp_rdata;
        logic        rsp_err;
    } icb_rsp_s_t;

    typedef struct packed {
        logic rsp_ready;
    } icb_rsp_m_t;
endpackage

module icb_addr_dec_5
    import icb_addr_dec_5_pkg::*;
#(
    parameter logic [31:0] S0_BASE     = 32'h1000_0000,
    parameter logic [31:0] S1_BASE     = 32'h2000_0000,
    parameter logic [31:0] S2_BASE     = 32'h3000_0000,
    parameter logic [31:0] S3_BASE     = 32'h4000_0000,
    parameter logic [31:0] S4_BASE     = 32'h5000_0000,
    parameter logic [31:0] REGION_MASK = 32'hF000_0000,
    parameter int          MAX_OST     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  icb_cmd_m_t m_cmd,
    output icb_cmd_s_t m_cmd_rsp,
    output icb_rsp_s_t m_rsp,
    input  icb_rsp_m_t m_rsp_ready,
    output icb_cmd_m_t x_cmd,
    input  icb_cmd_s_t x_cmd_rsp,
    input  icb_rsp_s_t x_rsp,
    output icb_rsp_m_t x_rsp_ready,
    output logic [2:0] sel
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OST);

    logic [1:0] state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [2:0] sel_q;

    logic       mapped;
    logic [2:0] dec_sel;
    logic       fwd;
    logic       x_cmd_hs, x_rsp_hs, err_hs;

    // Priority decode: lowest slave index wins when regions overlap.
    always_comb begin
        mapped  = 1'b1;
        dec_sel = 3'd0;
        if      ((m_cmd.addr & REGION_MASK) == (S0_BASE & REGION_MASK)) dec_sel = 3'd0;
        else if ((m_cmd.addr & REGION_MASK) == (S1_BASE & REGION_MASK)) dec_sel = 3'd1;
        else if ((m_cmd.addr & REGION_MASK) == (S2_BASE & REGION_MASK)) dec_sel = 3'd2;
        else if ((m_cmd.addr & REGION_MASK) == (S3_BASE & REGION_MASK)) dec_sel = 3'd3;
        else if ((m_cmd.addr & REGION_MASK) == (S4_BASE & REGION_MASK)) dec_sel = 3'd4;
        else                                                             mapped  = 1'b0;
    end

    // Forwarding gate uses registered cnt, so a same-cycle drain never
    // lets a different-slave command slip through.
    always_comb begin
        fwd             = 1'b0;
        sel             = sel_q;
        x_cmd           = m_cmd;
        x_cmd.valid     = 1'b0;
        m_cmd_rsp.ready = 1'b0;
        m_rsp           = x_rsp;
        x_rsp_ready     = m_rsp_ready;
        err_hs          = 1'b0;
        case (state)
            IDLE: begin
                if (m_cmd.valid && mapped) begin
                    sel = dec_sel;
                end
                if (mapped) begin
                    fwd             = 1'b1;
                    x_cmd.valid     = m_cmd.valid;
                    m_cmd_rsp.ready = m_cmd.valid & x_cmd_rsp.ready;
                end else begin
                    // Unmapped: accept locally, error response follows.
                    m_cmd_rsp.ready = m_cmd.valid;
                    err_hs          = m_cmd.valid;
                end
            end
            BUSY: begin
                fwd             = mapped && (dec_sel == sel_q) && (cnt < MAX_CNT);
                x_cmd.valid     = m_cmd.valid & fwd;
                m_cmd_rsp.ready = m_cmd.valid & fwd & x_cmd_rsp.ready;
            end
            default: begin
                m_rsp.rsp_valid      = 1'b1;
                m_rsp.rsp_rdata      = 32'h0;
                m_rsp.rsp_err        = 1'b1;
                x_rsp_ready.rsp_ready = 1'b0;
            end
        endcase
    end

    assign x_cmd_hs = x_cmd.valid & x_cmd_rsp.ready;
    assign x_rsp_hs = x_rsp.rsp_valid & x_rsp_ready.rsp_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    always_comb begin
        cnt_nxt = cnt;
        if (x_cmd_hs && !(x_rsp_hs && cnt != 4'd0)) begin
            cnt_nxt = cnt + 4'd1;
        end else if (!x_cmd_hs && x_rsp_hs && cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (x_cmd_hs)    state_nxt = BUSY;
                else if (err_hs) state_nxt = ERR;
            end
            BUSY: begin
                if (cnt_nxt == 4'd0) state_nxt = IDLE;
            end
            default: begin
                if (m_rsp_ready.rsp_ready) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            sel_q <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && x_cmd_hs) begin
                sel_q <= dec_sel;
            end
        end
    end

endmodule

// File: tb/tb_icb_addr_dec_5.sv
// tb/tb_icb_addr_dec_5.sv - scoreboard testbench for icb_addr_dec_5
module tb_icb_addr_dec_5;
    import icb_addr_dec_5_pkg::*;

    logic       clk;
    logic       rst_n;
    icb_cmd_m_t m_cmd;
    icb_cmd_s_t m_cmd_rsp;
    icb_rsp_s_t m_rsp;
    icb_rsp_m_t m_rsp_ready;
    icb_cmd_m_t x_cmd;
    icb_cmd_s_t x_cmd_rsp;
    icb_rsp_s_t x_rsp;
    icb_rsp_m_t x_rsp_ready;
    logic [2:0] sel;

    int tests = 0;
    int fails = 0;

    logic [35:0] exp_cmd_q[$];  // {sel, addr}
    logic [32:0] exp_rsp_q[$];  // {err, rdata}

    icb_addr_dec_5 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_cmd       (m_cmd),
        .m_cmd_rsp   (m_cmd_rsp),
        .m_rsp       (m_rsp),
        .m_rsp_ready (m_rsp_ready),
        .x_cmd       (x_cmd),
        .x_cmd_rsp   (x_cmd_rsp),
        .x_rsp       (x_rsp),
        .x_rsp_ready (x_rsp_ready),
        .sel         (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every forwarded command and every initiator-side response.
    always @(negedge clk) begin
        if (rst_n && x_cmd.valid && x_cmd_rsp.ready) begin
            if (exp_cmd_q.size() == 0) chk("unexpected_x_cmd", {sel, x_cmd.addr}, 36'h0);
            else chk("x_cmd", {sel, x_cmd.addr}, exp_cmd_q.pop_front());
        end
        if (rst_n && m_rsp.rsp_valid && m_rsp_ready.rsp_ready) begin
            if (exp_rsp_q.size() == 0) chk("unexpected_rsp", {3'd0, m_rsp.rsp_err, m_rsp.rsp_rdata}, 36'h0);
            else chk("m_rsp", {3'd0, m_rsp.rsp_err, m_rsp.rsp_rdata}, {3'd0, exp_rsp_q.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic v, input logic [31:0] a);
        m_cmd.valid = v;
        m_cmd.addr  = a;
        m_cmd.wdata = a ^ 32'h5A5A_5A5A;
    endtask

    task automatic rsp(input logic v, input logic [31:0] d);
        x_rsp.rsp_valid = v;
        x_rsp.rsp_rdata = d;
        x_rsp.rsp_err   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        m_cmd = '0;
        m_cmd.size = 2'd2;
        m_cmd.wmask = 4'hF;
        m_rsp_ready = '0;
        x_cmd_rsp = '0;
        x_rsp = '0;

        // Reset state
        @(negedge clk);
        chk("rst_sel", sel, 0);
        chk("rst_xvalid", x_cmd.valid, 0);
        chk("rst_rspvalid", m_rsp.rsp_valid, 0);
        chk("rst_ready", m_cmd_rsp.ready, 0);
        chk("rst_cnt", dut.cnt, 0);
        step();
        rst_n = 1'b1;
        step();

        // 1: single read to slave 1
        m_cmd.read = 1'b1;
        cmd(1, 32'h2000_0010);
        x_cmd_rsp.ready = 1'b1;
        exp_cmd_q.push_back({3'd1, 32'h2000_0010});
        @(negedge clk);
        chk("t1_sel", sel, 1);
        chk("t1_ready", m_cmd_rsp.ready, 1);
        step();
        cmd(0, 32'h0);
        rsp(1, 32'hCAFE_0001);
        m_rsp_ready.rsp_ready = 1'b1;
        exp_rsp_q.push_back({1'b0, 32'hCAFE_0001});
        @(negedge clk);
        chk("t1_cnt1", dut.cnt, 1);
        chk("t1_sel_busy", sel, 1);
        step();
        rsp(0, 32'h0);
        @(negedge clk);
        chk("t1_cnt0", dut.cnt, 0);

        // 2: four writes to slave 2 fill MAX_OST, fifth stalls
        step();
        m_cmd.read = 1'b0;
        m_rsp_ready.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd(1, 32'h3000_0000 + 32'(i * 4));
            exp_cmd_q.push_back({3'd2, 32'h3000_0000 + 32'(i * 4)});
            step();
        end
        cmd(1, 32'h3000_0010);
        @(negedge clk);
        chk("t2_cnt4", dut.cnt, 4);
        chk("t2_stall_ready", m_cmd_rsp.ready, 0);
        chk("t2_stall_xvalid", x_cmd.valid, 0);
        step();
        rsp(1, 32'h0000_0B01);
        m_rsp_ready.rsp_ready = 1'b1;
        exp_rsp_q.push_back({1'b0, 32'h0000_0B01});
        @(negedge clk);
        chk("t2_stall_on_rsp", m_cmd_rsp.ready, 0);
        step();
        rsp(0, 32'h0);
        exp_cmd_q.push_back({3'd2, 32'h3000_0010});
        @(negedge clk);
        chk("t2_cnt3", dut.cnt, 3);
        chk("t2_fifth_ready", m_cmd_rsp.ready, 1);
        step();
        cmd(0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rsp(1, 32'h0000_0B10 + 32'(i));
            exp_rsp_q.push_back({1'b0, 32'h0000_0B10 + 32'(i)});
            step();
        end
        rsp(0, 32'h0);
        @(negedge clk);
        chk("t2_drained", dut.cnt, 0);

        // 3: different-slave command waits for drain
        step();
        m_cmd.read = 1'b1;
        cmd(1, 32'h1000_0100);
        exp_cmd_q.push_back({3'd0, 32'h1000_0100});
        step();
        cmd(1, 32'h4000_0000);
        @(negedge clk);
        chk("t3_sel_hold", sel, 0);
        chk("t3_stall", m_cmd_rsp.ready, 0);
        step();
        rsp(1, 32'h1234_5678);
        exp_rsp_q.push_back({1'b0, 32'h1234_5678});
        @(negedge clk);
        chk("t3_stall_drain", m_cmd_rsp.ready, 0);
        chk("t3_sel_drain", sel, 0);
        step();
        rsp(0, 32'h0);
        exp_cmd_q.push_back({3'd3, 32'h4000_0000});
        @(negedge clk);
        chk("t3_sel3", sel, 3);
        chk("t3_xvalid", x_cmd.valid, 1);
        step();
        cmd(0, 32'h0);
        rsp(1, 32'h0000_0C03);
        exp_rsp_q.push_back({1'b0, 32'h0000_0C03});
        step();
        rsp(0, 32'h0);

        // 4: unmapped command, error response held
        m_rsp_ready.rsp_ready = 1'b0;
        x_cmd_rsp.ready = 1'b0;
        cmd(1, 32'h9000_0000);
        @(negedge clk);
        chk("t4_ready", m_cmd_rsp.ready, 1);
        chk("t4_xvalid", x_cmd.valid, 0);
        step();
        cmd(0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_err_held", {m_rsp.rsp_valid, m_rsp.rsp_err, m_rsp.rsp_rdata}, {2'b11, 32'h0});
            chk("t4_x_rsp_ready", x_rsp_ready.rsp_ready, 0);
            step();
        end
        m_rsp_ready.rsp_ready = 1'b1;
        exp_rsp_q.push_back({1'b1, 32'h0});
        step();
        m_rsp_ready.rsp_ready = 1'b0;
        @(negedge clk);
        chk("t4_err_done", m_rsp.rsp_valid, 0);

        // 5: simultaneous command and response at cnt=2
        step();
        x_cmd_rsp.ready = 1'b1;
        m_cmd.read = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd(1, 32'h5000_0000 + 32'(i * 4));
            exp_cmd_q.push_back({3'd4, 32'h5000_0000 + 32'(i * 4)});
            step();
        end
        cmd(1, 32'h5000_0008);
        exp_cmd_q.push_back({3'd4, 32'h5000_0008});
        rsp(1, 32'h0000_0D01);
        m_rsp_ready.rsp_ready = 1'b1;
        exp_rsp_q.push_back({1'b0, 32'h0000_0D01});
        @(negedge clk);
        chk("t5_ready", m_cmd_rsp.ready, 1);
        step();
        rsp(0, 32'h0);
        m_rsp_ready.rsp_ready = 1'b0;
        cmd(0, 32'h0);
        @(negedge clk);
        chk("t5_cnt2", dut.cnt, 2);
        chk("t5_sel4", sel, 4);

        // 6: asynchronous reset with cnt=3
        step();
        cmd(1, 32'h5000_000C);
        exp_cmd_q.push_back({3'd4, 32'h5000_000C});
        step();
        cmd(0, 32'h0);
        @(negedge clk);
        chk("t6_cnt3", dut.cnt, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cnt", dut.cnt, 0);
        chk("t6_rst_sel", sel, 0);
        chk("t6_rst_state", dut.state, 0);
        chk("t6_rst_xvalid", x_cmd.valid, 0);
        chk("t6_rst_rspvalid", m_rsp.rsp_valid, 0);
        step();
        rst_n = 1'b1;
        step();

        chk("cmd_q_empty", 36'(exp_cmd_q.size()), 0);
        chk("rsp_q_empty", 36'(exp_rsp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
